// File: rtl/lvt_mem_2w2r_if.sv
// Bus bundle for the 2-write / 2-read LVT memory: two write ports, two read
// address ports and the two registered read-data returns.
interface lvt_mem_2w2r_if #(
    parameter int BLOCKSIZE = 10,
    parameter int WIDTH     = 32
);
    logic                 en_w1;
    logic [BLOCKSIZE:0]   w1_addr;
    logic [WIDTH-1:0]     w1_din;
    logic                 en_w2;
    logic [BLOCKSIZE:0]   w2_addr;
    logic [WIDTH-1:0]     w2_din;
    logic [BLOCKSIZE:0]   r1_addr;
    logic [WIDTH-1:0]     d1;
    logic [BLOCKSIZE:0]   r2_addr;
    logic [WIDTH-1:0]     d2;

    modport master (
        output en_w1, w1_addr, w1_din,
        output en_w2, w2_addr, w2_din,
        output r1_addr, r2_addr,
        input  d1, d2
    );

    modport slave (
        input  en_w1, w1_addr, w1_din,
        input  en_w2, w2_addr, w2_din,
        input  r1_addr, r2_addr,
        output d1, d2
    );
endinterface

// File: rtl/lvt_mem_2w2r.sv
// Two-write, two-read memory built from four simple dual-port banks steered by
// a Live Value Table; unwritten addresses (since reset) read as zero.
module lvt_mem_2w2r #(
    parameter int BLOCKSIZE = 10,
    parameter int WIDTH     = 32
) (
    input  logic           clk,
    input  logic           rst,
    lvt_mem_2w2r_if.slave  bus
);
    localparam int AW    = BLOCKSIZE + 1;
    localparam int DEPTH = 2 << BLOCKSIZE;

    typedef logic [AW-1:0]    addr_t;
    typedef logic [WIDTH-1:0] word_t;

    // Bank storage: bankP_rN is written by write port P+1, read by read port N.
    word_t bank0_r1 [DEPTH];
    word_t bank0_r2 [DEPTH];
    word_t bank1_r1 [DEPTH];
    word_t bank1_r2 [DEPTH];

    logic [DEPTH-1:0] lvt_q, lvt_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    word_t rd0_r1_q, rd0_r2_q, rd1_r1_q, rd1_r2_q;
    logic  sel_r1_q, sel_r2_q;
    logic  vld_r1_q, vld_r2_q;

    logic  we1, we2;
    addr_t w1_addr, w2_addr, r1_addr, r2_addr;

    function automatic word_t live_word(input logic vld, input logic sel,
                                        input word_t b0, input word_t b1);
        if (!vld)
            return '0;
        return sel ? b1 : b0;
    endfunction

    assign w1_addr = bus.w1_addr;
    assign w2_addr = bus.w2_addr;
    assign r1_addr = bus.r1_addr;
    assign r2_addr = bus.r2_addr;
    assign we1     = bus.en_w1 & ~rst;
    assign we2     = bus.en_w2 & ~rst;

    // Bank write + synchronous read: read-old falls out of the RAM template.
    always_ff @(posedge clk) begin
        if (we1)
            bank0_r1[w1_addr] <= bus.w1_din;
        rd0_r1_q <= bank0_r1[r1_addr];
    end

    always_ff @(posedge clk) begin
        if (we1)
            bank0_r2[w1_addr] <= bus.w1_din;
        rd0_r2_q <= bank0_r2[r2_addr];
    end

    always_ff @(posedge clk) begin
        if (we2)
            bank1_r1[w2_addr] <= bus.w2_din;
        rd1_r1_q <= bank1_r1[r1_addr];
    end

    always_ff @(posedge clk) begin
        if (we2)
            bank1_r2[w2_addr] <= bus.w2_din;
        rd1_r2_q <= bank1_r2[r2_addr];
    end

    // Port 2 is applied last so it owns the LVT entry on a same-address collision.
    always_comb begin
        lvt_d   = lvt_q;
        valid_d = valid_q;
        if (bus.en_w1) begin
            lvt_d[w1_addr]   = 1'b0;
            valid_d[w1_addr] = 1'b1;
        end
        if (bus.en_w2) begin
            lvt_d[w2_addr]   = 1'b1;
            valid_d[w2_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvt_q   <= '0;
            valid_q <= '0;
        end else begin
            lvt_q   <= lvt_d;
            valid_q <= valid_d;
        end
    end

    // Read-side steering captured from pre-edge LVT/valid, aligned with bank reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_r1_q <= 1'b0;
            sel_r2_q <= 1'b0;
            vld_r1_q <= 1'b0;
            vld_r2_q <= 1'b0;
        end else begin
            sel_r1_q <= lvt_q[r1_addr];
            sel_r2_q <= lvt_q[r2_addr];
            vld_r1_q <= valid_q[r1_addr];
            vld_r2_q <= valid_q[r2_addr];
        end
    end

    assign bus.d1 = live_word(vld_r1_q, sel_r1_q, rd0_r1_q, rd1_r1_q);
    assign bus.d2 = live_word(vld_r2_q, sel_r2_q, rd0_r2_q, rd1_r2_q);
endmodule
